// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier feeding a downstream modulus stage.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               ready_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   modulus_in,
  input  logic               downstream_busy_in,
  output logic [2*WIDTH-1:0] product_out,
  output logic [WIDTH-1:0]   modulus_out,
  output logic               ready_out,
  output logic               busy_out,
  output logic               valid_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_t;

`ifdef MULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   modReg_q, modReg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   modulus_q, modulus_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
`ifdef MULT_RADIX4_EN
  logic [2*WIDTH-1:0] partial;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      modReg_q  <= '0;
      product_q <= '0;
      modulus_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      modReg_q  <= modReg_d;
      product_q <= product_d;
      modulus_q <= modulus_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    modReg_d  = modReg_q;
    product_d = product_q;
    modulus_d = modulus_q;
    ready_d   = 1'b0;
    valid_d   = 1'b0;
`ifdef MULT_RADIX4_EN
    partial   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (ready_in) begin
          mcand_d  = {{WIDTH{1'b0}}, a_in};
          mplier_d = b_in;
          modReg_d = modulus_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
`ifdef MULT_RADIX4_EN
        case (mplier_q[1:0])
          2'd1:    partial = mcand_q;
          2'd2:    partial = mcand_q << 1;
          2'd3:    partial = mcand_q + (mcand_q << 1);
          default: partial = '0;
        endcase
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
`else
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        // Fixed step count: zero operands still take the full duration.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!downstream_busy_in) begin
          product_d = acc_q;
          modulus_d = modReg_q;
          ready_d   = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product_out = product_q;
  assign modulus_out = modulus_q;
  assign ready_out   = ready_q;
  assign valid_out   = valid_q;
  assign busy_out    = (state_q == MULT) || (state_q == HOLD);

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; SHALL be even and >= 4.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 ready_in  input  1  start request; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  multiplicand.
REQ-006 b_in  input  WIDTH  multiplier.
REQ-007 modulus_in  input  WIDTH  modulus passed through to the downstream reduction stage.
REQ-008 downstream_busy_in  input  1  busy flag from the downstream modulus stage.
REQ-009 product_out  output  2*WIDTH  registered a*b; drives downstream value input.
REQ-010 modulus_out  output  WIDTH  registered modulus captured with the operands.
REQ-011 ready_out  output  1  one-cycle start pulse to the downstream stage.
REQ-012 busy_out  output  1  high from accept until hand-off.
REQ-013 valid_out  output  1  one-cycle completion pulse, coincident with ready_out.

Function
REQ-014 States SHALL be IDLE, MULT, HOLD; any unencoded state SHALL go to IDLE next edge.
REQ-015 IDLE with ready_in=1 SHALL capture a_in, b_in, modulus_in, clear accumulator and counter, set busy_out=1 and enter MULT at that edge.
REQ-016 ready_in outside IDLE SHALL be ignored; operands SHALL not change mid-operation.
REQ-017 MULT SHALL per edge add the shifted multiplicand to a 2*WIDTH accumulator when the multiplier LSB is 1, shift multiplicand left and multiplier right by one bit.
REQ-018 MULT SHALL last exactly WIDTH edges (no early exit on zero operands), then enter HOLD.
REQ-019 The accumulator SHALL be 2*WIDTH bits; no overflow is possible and none SHALL be flagged.
REQ-020 HOLD with downstream_busy_in=0 SHALL, at that edge, load product_out and modulus_out, drive ready_out=1 and valid_out=1 for the following cycle only, clear busy_out and enter IDLE.
REQ-021 HOLD with downstream_busy_in=1 SHALL remain in HOLD, busy_out=1, indefinitely.
REQ-022 Latency without stall: ready_out high in the cycle following the (WIDTH+1)th edge after the accepting edge.
REQ-023 product_out and modulus_out SHALL hold their values until the next hand-off.
REQ-024 ready_in=1 during the ready_out cycle SHALL be accepted (back-to-back throughput WIDTH+2 cycles).

Reset
REQ-025 rst_n_in low SHALL immediately force IDLE, product_out=0, modulus_out=0, ready_out=0, valid_out=0, busy_out=0, accumulator and counter 0.
REQ-026 Reset mid-MULT or mid-HOLD SHALL abort the operation with no ready_out pulse; the first edge after release SHALL see IDLE.

Configuration
REQ-027 Macro MULT_RADIX4_EN defined: MULT SHALL retire two multiplier bits per edge (adds 0, a, 2a or 3a), lasting WIDTH/2 edges; latency WIDTH/2+1.
REQ-028 MULT_RADIX4_EN undefined: radix-2 behaviour of REQ-017/018/022; results SHALL be identical in both builds.

Verification
REQ-029 WIDTH=16, a=3, b=5, mod=7, downstream idle -> product_out=0x0000000F, modulus_out=7, ready_out/valid_out one cycle, 17 edges after accept.
REQ-030 a=0xFFFF, b=0xFFFF -> product_out=0xFFFE0001; a=0, b=0x1234 -> product_out=0, same 17-edge latency.
REQ-031 downstream_busy_in held high 10 cycles after MULT ends -> stays HOLD, busy_out=1, no ready_out; drops -> ready_out next cycle, product correct.
REQ-032 rst_n_in low at edge 5 of MULT -> all outputs 0 immediately, no ready_out; new request after release (a=2, b=9) -> product_out=18.
REQ-033 ready_in re-asserted in ready_out cycle with a=0x0100, b=0x0100 -> accepted, second product_out=0x00010000 WIDTH+2 cycles later.
REQ-034 MULT_RADIX4_EN build, a=0xFFFF, b=0xFFFF -> product_out=0xFFFE0001 9 edges after accept.
